// File: rtl/code_rom_responder.sv
// Instruction-fetch bus responder: answers CPU reads from a loadable program memory
// over a tri-state data bus, with optional wait states. Define CODE_ROM_FETCH_CNT_EN for fetch_count.
module code_rom_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_bus,
  input  logic              read_en,
  inout  wire  [DATA_W-1:0] data_bus,
  output logic              bus_ready,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
`ifdef CODE_ROM_FETCH_CNT_EN
  ,
  output logic [15:0]       fetch_count
`endif
);

  localparam int unsigned DEPTH     = 1 << ADDR_W;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] dout_q,  dout_d;
  logic [3:0]        wcnt_q,  wcnt_d;
  logic              latch;
  logic              drive_en;

  // NOTE: program memory has no reset; a reset port on a RAM array blocks RAM inference
  // and the image must survive a CPU reset anyway.
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    wcnt_d  = wcnt_q;
    latch   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (read_en) latch = 1'b1;
      end
      ST_WAIT: begin
        if (!read_en) begin
          state_d = ST_IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q == 4'd1) begin
          state_d = ST_DRIVE;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ST_DRIVE: begin
        if (!read_en)                 state_d = ST_IDLE;
        else if (addr_bus != addr_q)  latch   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // The memory read happens before this edge's load lands, so a same-edge load
    // and latch on one address returns the old word.
    if (latch) begin
      addr_d = addr_bus;
      dout_d = mem[addr_bus];
      if (WAIT_STATES == 0) begin
        state_d = ST_DRIVE;
      end else begin
        state_d = ST_WAIT;
        wcnt_d  = WAIT_INIT;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      dout_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Gated by read_en directly so the bus is released in the cycle read_en falls.
  assign drive_en  = (state_q == ST_DRIVE) && read_en;
  assign bus_ready = drive_en;
  assign data_bus  = drive_en ? dout_q : {DATA_W{1'bz}};

`ifdef CODE_ROM_FETCH_CNT_EN
  logic [15:0] fcnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     fcnt_q <= '0;
    else if (latch) fcnt_q <= fcnt_q + 16'd1;
  end

  assign fetch_count = fcnt_q;
`endif

endmodule
